lvt_read_port: RTL and testbench

LVT_READ_PORT -- requirements
Module: lvt_read_port

---
 rtl/lvt_read_port.sv | 116 +++++++++++
 tb/tb_lvt_read_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_read_port.sv
// Read port of a live-value-table multi-write memory: tracks which bank holds the latest
// write per address, reads all banks in parallel and returns the live one through a 2-entry FIFO.
module lvt_read_port #(
  parameter int unsigned NB_WRAGENT = 2,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned SELW      = (NB_WRAGENT > 1) ? $clog2(NB_WRAGENT) : 1
) (
  input  logic                             rdclk,
  input  logic                             rst_n,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic [NB_WRAGENT-1:0]            bank_rden,
  output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_rdaddr,
  input  logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_rddata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [SELW-1:0]                  rsp_bank
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNTW       = 2;
  localparam int unsigned OCCW       = 3;

  logic [SELW-1:0]       lvt_q [RAM_DEPTH];
  logic                  pend_q;
  logic [SELW-1:0]       pend_sel_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [SELW-1:0]       fifo_bank_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [CNTW-1:0]       cnt_q;
  logic [CNTW-1:0]       cnt_d;
  logic [OCCW-1:0]       occ;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] sel_data;

  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = pend_q;

  // Occupancy counts the in-flight bank read so the FIFO can never overflow.
  always_comb begin
    occ       = OCCW'(cnt_q) + OCCW'(pend_q) - OCCW'(pop);
    req_ready = rst_n && (occ < OCCW'(FIFO_DEPTH));
  end

  assign accept      = req_valid && req_ready;
  assign bank_rden   = {NB_WRAGENT{accept}};
  assign bank_rdaddr = {NB_WRAGENT{req_addr}};

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
      if (pend_sel_q == SELW'(i)) sel_data = bank_rddata[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Ascending loop order lets the highest agent index win on colliding writes.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < RAM_DEPTH; e++) lvt_q[e] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
        if (wren[i]) lvt_q[wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]] <= SELW'(i);
      end
    end
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_sel_q <= '0;
    end else begin
      pend_q <= accept;
      if (accept) pend_sel_q <= lvt_q[req_addr];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNTW'(1);
    else if (!push && pop) cnt_d = cnt_q - CNTW'(1);
  end

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
        fifo_data_q[e] <= '0;
        fifo_bank_q[e] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= sel_data;
        fifo_bank_q[wr_ptr_q] <= pend_sel_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign rsp_data = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_bank = rsp_valid ? fifo_bank_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_lvt_read_port.sv
// Directed bench for lvt_read_port with a behavioural two-bank memory model.
module tb_lvt_read_port;

  logic        rdclk = 1'b0;
  logic        rst_n;
  logic [1:0]  wren;
  logic [5:0]  wraddr;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [1:0]  bank_rden;
  logic [5:0]  bank_rdaddr;
  logic [15:0] bank_rddata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [0:0]  rsp_bank;

  logic [7:0]  wd [2];
  logic [7:0]  bank_mem [2][8];
  logic [7:0]  rd_q [2];
  logic        mem_init;
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 rdclk = ~rdclk;

  lvt_read_port dut (
    .rdclk       (rdclk),
    .rst_n       (rst_n),
    .wren        (wren),
    .wraddr      (wraddr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .bank_rden   (bank_rden),
    .bank_rdaddr (bank_rdaddr),
    .bank_rddata (bank_rddata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_bank    (rsp_bank)
  );

  // Bank model: synchronous read, one cycle latency; bank0 = 0x37+a, bank1 = 0x80+a.
  always @(posedge rdclk) begin
    for (int b = 0; b < 2; b++) begin
      if (!mem_init) begin
        for (int a = 0; a < 8; a++) bank_mem[b][a] <= (b == 0) ? 8'h37 + 8'(a) : 8'h80 + 8'(a);
      end else if (wren[b]) begin
        bank_mem[b][wraddr[3*b +: 3]] <= wd[b];
      end
      if (bank_rden[b]) rd_q[b] <= bank_mem[b][bank_rdaddr[3*b +: 3]];
    end
  end
  assign bank_rddata = {rd_q[1], rd_q[0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rdclk);
    #1;
  endtask

  task automatic write2(input logic [1:0] en, input logic [2:0] a0, input logic [7:0] d0,
                        input logic [2:0] a1, input logic [7:0] d1);
    wren   = en;
    wraddr = {a1, a0};
    wd[0]  = d0;
    wd[1]  = d1;
    tick();
    wren = 2'b00;
  endtask

  task automatic read_one(input string tag, input logic [2:0] a, input logic exp_b,
                          input logic [7:0] exp_d);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    #1;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    tick();
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, "_bank"},  32'(rsp_bank),  32'(exp_b));
    check_eq({tag, "_data"},  32'(rsp_data),  32'(exp_d));
    tick();
  endtask

  logic [7:0] bp_d [3] = '{8'h38, 8'h22, 8'hA5};
  logic       bp_b [3] = '{1'b0, 1'b1, 1'b1};
  logic [7:0] bb_d [8] = '{8'h37, 8'h38, 8'h22, 8'hA5, 8'h3B, 8'h3C, 8'h3D, 8'h3E};
  logic       bb_b [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int idx;
    mem_init  = 1'b0;
    rst_n     = 1'b0;
    wren      = 2'b00;
    wraddr    = '0;
    wd[0]     = '0;
    wd[1]     = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    mem_init  = 1'b1;

    // Reset: outputs quiet even with a request offered
    req_valid = 1'b1;
    req_addr  = 3'd5;
    #1;
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rden",  32'(bank_rden), 32'd0);
    check_eq("rst_data",  32'(rsp_data),  32'd0);
    check_eq("rst_bank",  32'(rsp_bank),  32'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check_eq("rel_ready", 32'(req_ready), 32'd1);
    tick();

    // Unwritten address 5 reads bank0 with exact two-cycle latency
    req_valid = 1'b1;
    req_addr  = 3'd5;
    rsp_ready = 1'b1;
    #1;
    check_eq("a5_ready",  32'(req_ready),   32'd1);
    check_eq("a5_rden",   32'(bank_rden),   32'h3);
    check_eq("a5_rdaddr", 32'(bank_rdaddr), 32'h2D);
    tick();
    req_valid = 1'b0;
    #1;
    check_eq("a5_n1_valid", 32'(rsp_valid), 32'd0);
    check_eq("a5_n1_rden",  32'(bank_rden), 32'd0);
    tick();
    check_eq("a5_valid", 32'(rsp_valid), 32'd1);
    check_eq("a5_bank",  32'(rsp_bank),  32'd0);
    check_eq("a5_data",  32'(rsp_data),  32'h3C);
    tick();
    check_eq("a5_popped", 32'(rsp_valid), 32'd0);

    write2(2'b10, 3'd0, 8'h00, 3'd3, 8'hA5);
    read_one("w1a3", 3'd3, 1'b1, 8'hA5);

    write2(2'b11, 3'd2, 8'h11, 3'd2, 8'h22);
    read_one("coll", 3'd2, 1'b1, 8'h22);

    // Backpressure: third request waits until a response drains
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 3'd1;
    #1;
    check_eq("bp_rdy0", 32'(req_ready), 32'd1);
    tick();
    req_addr = 3'd2;
    #1;
    check_eq("bp_rdy1", 32'(req_ready), 32'd1);
    tick();
    req_addr = 3'd3;
    #1;
    check_eq("bp_rdy2",   32'(req_ready), 32'd0);
    check_eq("bp_hold_v", 32'(rsp_valid), 32'd1);
    check_eq("bp_hold_d", 32'(rsp_data),  32'h38);
    tick();
    check_eq("bp_rdy3",   32'(req_ready), 32'd0);
    check_eq("bp_stab_d", 32'(rsp_data),  32'h38);
    check_eq("bp_stab_b", 32'(rsp_bank),  32'd0);
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_rdy_pop", 32'(req_ready), 32'd1);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid && idx < 3) begin
        check_eq("bp_rsp_d", 32'(rsp_data), 32'(bp_d[idx]));
        check_eq("bp_rsp_b", 32'(rsp_bank), 32'(bp_b[idx]));
        idx++;
      end
      tick();
      req_valid = 1'b0;
      #1;
    end
    check_eq("bp_count", 32'(idx), 32'd3);
    check_eq("bp_empty", 32'(rsp_valid), 32'd0);

    // Back-to-back reads of every address at full throughput
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8);
      req_addr  = 3'(k);
      #1;
      if (k < 8) check_eq("bb_ready", 32'(req_ready), 32'd1);
      if (k >= 2 && k < 10) begin
        check_eq("bb_valid", 32'(rsp_valid), 32'd1);
        check_eq("bb_data",  32'(rsp_data),  32'(bb_d[k-2]));
        check_eq("bb_bank",  32'(rsp_bank),  32'(bb_b[k-2]));
      end else begin
        check_eq("bb_idle", 32'(rsp_valid), 32'd0);
      end
      tick();
    end
    req_valid = 1'b0;

    // Reset while a response is in flight: discarded, LVT cleared
    write2(2'b10, 3'd0, 8'h00, 3'd3, 8'h5A);
    req_valid = 1'b1;
    req_addr  = 3'd3;
    #1;
    check_eq("mr_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_eq("mr_valid", 32'(rsp_valid), 32'd0);
    check_eq("mr_rdy",   32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("mr_quiet", 32'(rsp_valid), 32'd0);
      tick();
    end
    read_one("mr_a3", 3'd3, 1'b0, 8'h3A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
